// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - two-requester round-robin controller for a 4 x 16-bit register bank
// Optional grant locking is compiled in with `define REG_BANK_ARB_LOCK_EN.
module reg_bank_arbiter #(
   parameter int WIDTH = 16,
   parameter int NREG  = 4
) (
   input  logic                       Clock,
   input  logic                       Reset,
   input  logic                       ReqA_Valid,
   output logic                       ReqA_Ready,
   input  logic [$clog2(NREG)-1:0]    ReqA_RegSel,
   input  logic [1:0]                 ReqA_FunSel,
   input  logic [WIDTH-1:0]           ReqA_Data,
   input  logic                       ReqA_Lock,
   input  logic                       ReqB_Valid,
   output logic                       ReqB_Ready,
   input  logic [$clog2(NREG)-1:0]    ReqB_RegSel,
   input  logic [1:0]                 ReqB_FunSel,
   input  logic [WIDTH-1:0]           ReqB_Data,
   input  logic                       ReqB_Lock,
   output logic [NREG-1:0]            RegE,
   output logic [1:0]                 RegFunSel,
   output logic [WIDTH-1:0]           RegI,
   input  logic [NREG*WIDTH-1:0]      RegQ,
   output logic                       RspValid,
   input  logic                       RspReady,
   output logic                       RspOwner,
   output logic [WIDTH-1:0]           RspData,
   output logic                       Busy
);

   localparam int SELW = $clog2(NREG);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      SAMPLE = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [SELW-1:0]   sel_q;
   logic [1:0]        fun_q;
   logic [WIDTH-1:0]  data_q;
   logic              owner_q;
   logic              last_served;
   logic [WIDTH-1:0]  rsp_data_q;
   logic              rsp_owner_q;

   logic              any_valid;
   logic              win_b;
   logic              accept;
   logic [WIDTH-1:0]  q_sel;
   logic              lock_win;

`ifdef REG_BANK_ARB_LOCK_EN
   logic              lock_q;
   logic              lock_hold;

   // lock_hold is only honoured in the first IDLE cycle after the locked command
   assign lock_win = lock_hold;
`else
   logic              unused_lock;

   assign unused_lock = ReqA_Lock | ReqB_Lock;
   assign lock_win    = 1'b0;
`endif

   assign any_valid = ReqA_Valid | ReqB_Valid;
   assign accept    = (state == IDLE) && any_valid;

   // win_b = 1 selects requester B; on a tie the one not served last wins
   always_comb begin
      win_b = ~last_served;
      if (ReqA_Valid && !ReqB_Valid) begin
         win_b = 1'b0;
      end else if (ReqB_Valid && !ReqA_Valid) begin
         win_b = 1'b1;
      end else if (lock_win) begin
         win_b = last_served;
      end
   end

   always_comb begin
      q_sel = '0;
      for (int k = 0; k < NREG; k++) begin
         if (sel_q == SELW'(k)) begin
            q_sel = RegQ[k*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      ReqA_Ready = 1'b0;
      ReqB_Ready = 1'b0;
      RegE       = '0;
      RegFunSel  = 2'b00;
      RegI       = '0;
      case (state)
         IDLE: begin
            ReqA_Ready = any_valid & ~win_b;
            ReqB_Ready = any_valid & win_b;
            if (any_valid) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            RegE       = NREG'(1) << sel_q;
            RegFunSel  = fun_q;
            RegI       = data_q;
            state_next = SAMPLE;
         end
         SAMPLE: begin
            state_next = RESP;
         end
         RESP: begin
            if (RspReady) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sel_q       <= '0;
         fun_q       <= 2'b00;
         data_q      <= '0;
         owner_q     <= 1'b0;
         last_served <= 1'b1;
         rsp_data_q  <= '0;
         rsp_owner_q <= 1'b0;
      end else begin
         if (accept) begin
            sel_q   <= win_b ? ReqB_RegSel : ReqA_RegSel;
            fun_q   <= win_b ? ReqB_FunSel : ReqA_FunSel;
            data_q  <= win_b ? ReqB_Data   : ReqA_Data;
            owner_q <= win_b;
         end
         if (state == SAMPLE) begin
            rsp_data_q  <= q_sel;
            rsp_owner_q <= owner_q;
            last_served <= owner_q;
         end
      end
   end

`ifdef REG_BANK_ARB_LOCK_EN
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         lock_q    <= 1'b0;
         lock_hold <= 1'b0;
      end else begin
         if (accept) begin
            lock_q <= win_b ? ReqB_Lock : ReqA_Lock;
         end
         if (state == SAMPLE) begin
            lock_hold <= lock_q;
         end else if (state == IDLE) begin
            lock_hold <= 1'b0;
         end
      end
   end
`endif

   assign RspValid = (state == RESP);
   assign RspOwner = rsp_owner_q;
   assign RspData  = rsp_data_q;
   assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - self-checking bench for reg_bank_arbiter with a behavioural register bank
// Expectations follow REG_BANK_ARB_LOCK_EN when it is defined for the build.
module tb_reg_bank_arbiter;

   localparam int WIDTH = 16;
   localparam int NREG  = 4;

   logic              Clock = 1'b0;
   logic              Reset = 1'b0;
   logic              ReqA_Valid, ReqA_Ready, ReqA_Lock;
   logic [1:0]        ReqA_RegSel, ReqA_FunSel;
   logic [WIDTH-1:0]  ReqA_Data;
   logic              ReqB_Valid, ReqB_Ready, ReqB_Lock;
   logic [1:0]        ReqB_RegSel, ReqB_FunSel;
   logic [WIDTH-1:0]  ReqB_Data;
   logic [NREG-1:0]   RegE;
   logic [1:0]        RegFunSel;
   logic [WIDTH-1:0]  RegI;
   logic [NREG*WIDTH-1:0] RegQ;
   logic              RspValid, RspReady, RspOwner, Busy;
   logic [WIDTH-1:0]  RspData;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] bank [4];
   logic [15:0] ref_regs [4];
   bit          tb_last;

   reg_bank_arbiter #(.WIDTH(WIDTH), .NREG(NREG)) dut (
      .Clock(Clock), .Reset(Reset),
      .ReqA_Valid(ReqA_Valid), .ReqA_Ready(ReqA_Ready), .ReqA_RegSel(ReqA_RegSel),
      .ReqA_FunSel(ReqA_FunSel), .ReqA_Data(ReqA_Data), .ReqA_Lock(ReqA_Lock),
      .ReqB_Valid(ReqB_Valid), .ReqB_Ready(ReqB_Ready), .ReqB_RegSel(ReqB_RegSel),
      .ReqB_FunSel(ReqB_FunSel), .ReqB_Data(ReqB_Data), .ReqB_Lock(ReqB_Lock),
      .RegE(RegE), .RegFunSel(RegFunSel), .RegI(RegI), .RegQ(RegQ),
      .RspValid(RspValid), .RspReady(RspReady), .RspOwner(RspOwner),
      .RspData(RspData), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   initial begin
      for (int k = 0; k < 4; k++) bank[k] = 16'h0000;
   end

   // External Register16bit-style bank: enabled register applies FunSel at the edge
   always @(posedge Clock) begin
      for (int k = 0; k < 4; k++) begin
         if (RegE[k]) begin
            case (RegFunSel)
               2'b00: bank[k] <= bank[k] - 16'd1;
               2'b01: bank[k] <= bank[k] + 16'd1;
               2'b10: bank[k] <= RegI;
               default: bank[k] <= 16'h0000;
            endcase
         end
      end
   end

   assign RegQ = {bank[3], bank[2], bank[1], bank[0]};

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] apply_op(input logic [15:0] v, input logic [1:0] f, input logic [15:0] d);
      case (f)
         2'b00:   return v - 16'd1;
         2'b01:   return v + 16'd1;
         2'b10:   return d;
         default: return 16'h0000;
      endcase
   endfunction

   // Spec arbitration rule: single valid wins; tie goes to the one not served last unless lock holds
   function automatic bit pick(input bit va, input bit vb, input bit last, input bit hold);
      if (va && !vb) return 1'b0;
      if (vb && !va) return 1'b1;
`ifdef REG_BANK_ARB_LOCK_EN
      if (hold) return last;
`endif
      return !last;
   endfunction

   task automatic drive(input bit who, input bit v, input logic [1:0] s, input logic [1:0] f,
                        input logic [15:0] d, input bit l);
      if (!who) begin
         ReqA_Valid = v; ReqA_RegSel = s; ReqA_FunSel = f; ReqA_Data = d; ReqA_Lock = l;
      end else begin
         ReqB_Valid = v; ReqB_RegSel = s; ReqB_FunSel = f; ReqB_Data = d; ReqB_Lock = l;
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rege"},     RegE, 0);
      chk({tag, "_funsel"},   RegFunSel, 0);
      chk({tag, "_regi"},     RegI, 0);
      chk({tag, "_rspvalid"}, RspValid, 0);
      chk({tag, "_rspowner"}, RspOwner, 0);
      chk({tag, "_rspdata"},  RspData, 0);
      chk({tag, "_busy"},     Busy, 0);
   endtask

   typedef struct {
      bit          who;
      logic [1:0]  sel;
      logic [1:0]  fun;
      logic [15:0] data;
      logic [15:0] exp;
   } vec_t;

   task automatic issue_one(input vec_t v);
      int t;
      logic rdy;
      logic [3:0] oh;
      oh = 4'b0001 << v.sel;
      @(negedge Clock);
      drive(v.who, 1, v.sel, v.fun, v.data, 0);
      #1;
      t = 0;
      rdy = v.who ? ReqB_Ready : ReqA_Ready;
      while (!rdy && t < 10) begin
         @(negedge Clock); #1; t++;
         rdy = v.who ? ReqB_Ready : ReqA_Ready;
      end
      chk("tbl_ready", rdy, 1);
      chk("tbl_other_ready", v.who ? ReqA_Ready : ReqB_Ready, 0);
      @(negedge Clock);
      drive(v.who, 0, v.sel, v.fun, v.data, 0);
      #1;
      chk("tbl_issue_rege", RegE, oh);
      chk("tbl_issue_funsel", RegFunSel, v.fun);
      chk("tbl_issue_regi", RegI, v.data);
      chk("tbl_issue_busy", Busy, 1);
      chk("tbl_issue_rspvalid", RspValid, 0);
      @(negedge Clock); #1;
      chk("tbl_sample_rege", RegE, 0);
      chk("tbl_sample_rspvalid", RspValid, 0);
      @(negedge Clock); #1;
      chk("tbl_resp_valid", RspValid, 1);
      chk("tbl_resp_data", RspData, v.exp);
      chk("tbl_resp_owner", RspOwner, v.who);
      @(negedge Clock); #1;
      chk("tbl_back_idle", Busy, 0);
      ref_regs[v.sel] = v.exp;
      tb_last = v.who;
   endtask

   task automatic run_both(input int n, input bit a_lock, output logic [3:0] seq);
      int got, cyc, t;
      logic a_rdy;
      seq = 4'b0000;
      @(negedge Clock);
      drive(0, 1, 2'd0, 2'd2, 16'hA0A0, a_lock);
      drive(1, 1, 2'd3, 2'd2, 16'hB0B0, 0);
      got = 0;
      cyc = 0;
      while (got < n && cyc < 80) begin
         #1;
         if (RspValid) begin
            seq[got] = RspOwner;
            chk("rr_data", RspData, RspOwner ? 16'hB0B0 : 16'hA0A0);
            got++;
         end
         if (Busy) chk("rr_ready_busy", {ReqA_Ready, ReqB_Ready}, 0);
         a_rdy = ReqA_Ready;
         @(negedge Clock);
         cyc++;
         if (a_rdy) ReqA_Lock = 1'b0;
      end
      ReqA_Valid = 0;
      ReqB_Valid = 0;
      #1;
      t = 0;
      while (Busy && t < 10) begin
         @(negedge Clock); #1; t++;
      end
      chk("rr_count", got, n);
      chk("rr_drained", Busy, 0);
      ref_regs[0] = 16'hA0A0;
      ref_regs[3] = 16'hB0B0;
      tb_last = seq[n-1];
   endtask

   vec_t tbl [10];

   initial begin
      logic [3:0]  seq;
      logic [15:0] exp_d;
      int t;
      bit          pend [2];
      logic [1:0]  p_sel [2];
      logic [1:0]  p_fun [2];
      logic [15:0] p_dat [2];
      bit          p_lck [2];
      int          phase;
      bit          hold, w, exp_owner;
      logic [1:0]  c_sel, c_fun;
      logic [15:0] c_dat, exp_rsp;
      logic [3:0]  oh;

      tbl[0] = '{0, 2'd2, 2'd2, 16'h1234, 16'h1234};
      tbl[1] = '{1, 2'd1, 2'd2, 16'h0000, 16'h0000};
      tbl[2] = '{1, 2'd1, 2'd0, 16'hDEAD, 16'hFFFF};
      tbl[3] = '{1, 2'd1, 2'd1, 16'hDEAD, 16'h0000};
      tbl[4] = '{1, 2'd1, 2'd1, 16'hBEEF, 16'h0001};
      tbl[5] = '{0, 2'd3, 2'd2, 16'hFFFF, 16'hFFFF};
      tbl[6] = '{0, 2'd3, 2'd1, 16'h5A5A, 16'h0000};
      tbl[7] = '{0, 2'd0, 2'd0, 16'h0000, 16'hFFFF};
      tbl[8] = '{0, 2'd2, 2'd3, 16'h7777, 16'h0000};
      tbl[9] = '{1, 2'd2, 2'd1, 16'h0000, 16'h0001};

      for (int k = 0; k < 4; k++) ref_regs[k] = 16'h0000;
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      RspReady = 1'b1;

      repeat (3) @(negedge Clock);
      #1;
      chk_reset_vals("in_reset");
      Reset = 1'b1;
      @(negedge Clock); #1;
      chk_reset_vals("post_reset");
      chk("post_reset_ready", {ReqA_Ready, ReqB_Ready}, 0);
      tb_last = 1'b1;

      for (int i = 0; i < 10; i++) issue_one(tbl[i]);

      // Reset asserted while the bank is being written
      @(negedge Clock);
      drive(0, 1, 2'd1, 2'd2, 16'h5555, 0);
      #1;
      chk("rst_accept", ReqA_Ready, 1);
      @(negedge Clock); #1;
      chk("rst_issue_rege", RegE, 4'b0010);
      Reset = 1'b0;
      ReqA_Valid = 1'b0;
      #1;
      chk_reset_vals("mid_reset");
      @(negedge Clock);
      Reset = 1'b1;
      for (int k = 0; k < 4; k++) ref_regs[k] = bank[k];
      tb_last = 1'b1;

      run_both(4, 0, seq);
      chk("rr_grant0", seq[0], 0);
      chk("rr_grant1", seq[1], 1);
      chk("rr_grant2", seq[2], 0);
      chk("rr_grant3", seq[3], 1);

      run_both(3, 1, seq);
      chk("lock_grant0", seq[0], 0);
`ifdef REG_BANK_ARB_LOCK_EN
      chk("lock_grant1", seq[1], 0);
      chk("lock_grant2", seq[2], 1);
`else
      chk("lock_grant1", seq[1], 1);
      chk("lock_grant2", seq[2], 0);
`endif

      // Response back-pressure
      RspReady = 1'b0;
      exp_d = apply_op(ref_regs[2], 2'd1, 16'h0);
      @(negedge Clock);
      drive(0, 1, 2'd2, 2'd1, 16'h0000, 0);
      #1;
      t = 0;
      while (!ReqA_Ready && t < 10) begin
         @(negedge Clock); #1; t++;
      end
      chk("stall_accept", ReqA_Ready, 1);
      @(negedge Clock);
      ReqA_Valid = 1'b0;
      drive(1, 1, 2'd1, 2'd3, 16'h0000, 0);
      @(negedge Clock);
      @(negedge Clock); #1;
      chk("stall_first_valid", RspValid, 1);
      chk("stall_first_data", RspData, exp_d);
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock); #1;
         chk("stall_valid", RspValid, 1);
         chk("stall_data", RspData, exp_d);
         chk("stall_owner", RspOwner, 0);
         chk("stall_ready", {ReqA_Ready, ReqB_Ready}, 0);
         chk("stall_rege", RegE, 0);
      end
      ReqB_Valid = 1'b0;
      RspReady = 1'b1;
      @(negedge Clock); #1;
      chk("stall_release", Busy, 0);
      ref_regs[2] = exp_d;
      tb_last = 1'b0;

      // Randomized traffic against the behavioural model
      pend[0] = 0; pend[1] = 0;
      p_sel[0] = 0; p_sel[1] = 0; p_fun[0] = 0; p_fun[1] = 0;
      p_dat[0] = 0; p_dat[1] = 0; p_lck[0] = 0; p_lck[1] = 0;
      phase = 0; hold = 0; exp_owner = 0; exp_rsp = 0;
      c_sel = 0; c_fun = 0; c_dat = 0;
      for (int cyc = 0; cyc < 1200; cyc++) begin
         @(negedge Clock);
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && ($urandom % 3) == 0) begin
               pend[r]  = 1;
               p_sel[r] = 2'($urandom);
               p_fun[r] = 2'($urandom);
               p_dat[r] = 16'($urandom);
               p_lck[r] = 1'($urandom);
            end else if (pend[r] && phase == 0 && ($urandom % 8) == 0) begin
               pend[r] = 0;
            end
            drive(r[0], pend[r], p_sel[r], p_fun[r], p_dat[r], p_lck[r]);
         end
         RspReady = ($urandom % 4) != 0;
         #1;
         chk("rnd_busy", Busy, phase != 0);
         chk("rnd_rspvalid", RspValid, phase == 3);
         oh = 4'b0001 << c_sel;
         chk("rnd_rege", RegE, (phase == 1) ? oh : 4'b0000);
         if (phase == 1) begin
            chk("rnd_funsel", RegFunSel, c_fun);
            chk("rnd_regi", RegI, c_dat);
         end
         if (phase == 3) begin
            chk("rnd_rspdata", RspData, exp_rsp);
            chk("rnd_rspowner", RspOwner, exp_owner);
         end
         if (phase == 0) begin
            w = pick(pend[0], pend[1], tb_last, hold);
            hold = 0;
            chk("rnd_ready_a", ReqA_Ready, (pend[0] || pend[1]) && !w);
            chk("rnd_ready_b", ReqB_Ready, (pend[0] || pend[1]) && w);
            if (pend[0] || pend[1]) begin
               c_sel = p_sel[w]; c_fun = p_fun[w]; c_dat = p_dat[w];
               exp_rsp = apply_op(ref_regs[c_sel], c_fun, c_dat);
               ref_regs[c_sel] = exp_rsp;
               exp_owner = w;
               tb_last = w;
               hold = p_lck[w];
               pend[w] = 0;
               phase = 1;
            end
         end else begin
            chk("rnd_ready_busy", {ReqA_Ready, ReqB_Ready}, 0);
            if (phase == 3) begin
               if (RspReady) phase = 0;
            end else begin
               phase = phase + 1;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Controller that shares a bank of four external 16-bit Register16bit-style registers between two requesters (A and B). Each requester issues register commands (decrement, increment, load, clear) over a valid/ready handshake. The block arbitrates round-robin and drives the bank's per-register enable and shared FunSel/I lines for exactly one cycle per command. It then reads the updated register back and returns it on a response handshake. It sits between the control unit / address unit and the general-purpose register bank.

## Interface
- WIDTH, 16, register data width.
- NREG, 4, number of registers in the bank; RegSel width is 2.
- Clock  in  1  single clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- ReqA_Valid / ReqB_Valid  in  1  requester has a command pending.
- ReqA_Ready / ReqB_Ready  out  1  command accepted on this edge when Valid is also high.
- ReqA_RegSel / ReqB_RegSel  in  2  target register index.
- ReqA_FunSel / ReqB_FunSel  in  2  00 decrement, 01 increment, 10 load, 11 clear.
- ReqA_Data / ReqB_Data  in  WIDTH  load value; don't-care unless FunSel = 10.
- ReqA_Lock / ReqB_Lock  in  1  request to keep the grant (see Configuration).
- RegE  out  NREG  one-hot enable to the bank registers.
- RegFunSel  out  2  shared FunSel to the bank.
- RegI  out  WIDTH  shared load data to the bank.
- RegQ  in  NREG*WIDTH  concatenated bank outputs; register k is at [k*WIDTH +: WIDTH].
- RspValid  out  1  response available.
- RspReady  in  1  consumer accepts the response.
- RspOwner  out  1  0 = A, 1 = B.
- RspData  out  WIDTH  register value after the command.
- Busy  out  1  high in every state except IDLE.

## Operation
- FSM states are IDLE, ISSUE, SAMPLE, RESP.
- IDLE: the arbiter picks a winner from the Valids.
  - If only one Valid is high, that requester wins.
  - If both are high, the winner is the requester not served last (round-robin). LastServed resets to B, so A wins the first tie.
  - Ready is asserted combinationally, only to the winner and only in IDLE.
  - On the accept edge, RegSel, FunSel, Data and the owner are latched, and the FSM moves to ISSUE.
- ISSUE: RegE is one-hot at the latched RegSel, and RegFunSel/RegI carry the latched command. The register updates at the end of this cycle. Next state is SAMPLE.
- SAMPLE: RegE = 0. RspData is captured from RegQ[sel], RspOwner is set, and LastServed is updated to the owner. Next state is RESP.
- RESP: RspValid = 1, held until RspValid && RspReady, then the FSM returns to IDLE. RspData and RspOwner stay stable while RspValid is high.
- Arithmetic: the bank wraps modulo 2^16, so decrement of 0x0000 gives 0xFFFF and increment of 0xFFFF gives 0x0000. The controller reports the wrapped value unchanged.
- Requesters:
  - Must hold Valid and all command fields stable until Ready.
  - May drop Valid before acceptance; no command is issued in that case.
  - A requester losing arbitration keeps waiting; it wins the next IDLE cycle after the other requester is served.
- No new command is accepted outside IDLE; both Ready outputs are 0 in ISSUE, SAMPLE and RESP.

## Timing
- Reset values: state IDLE, RegE = 0, RegFunSel = 00, RegI = 0, RspValid = 0, RspOwner = 0, RspData = 0, Busy = 0, LastServed = B.
- Reset takes effect immediately and asynchronously, including mid-command. If it asserts during ISSUE, RegE drops at once and the bank write may or may not occur. Any pending response is discarded.
- Latency: with accept on edge N, RegE is high in cycle N..N+1 and the register updates at edge N+1. RspValid rises after edge N+2.
- Best-case issue rate is one command per 4 cycles (accept, ISSUE, SAMPLE, RESP with RspReady already high).
- Exactly one RegE bit is high for exactly one cycle per accepted command; RegE is never high outside ISSUE.

## Configuration
- REG_BANK_ARB_LOCK_EN defined:
  - If the command just served had Lock = 1 and the same requester has Valid high in the next IDLE cycle, that requester wins even when the other is valid.
  - LastServed still updates.
  - Lock is sampled with the command on the accept edge.
- Undefined: the Lock inputs are ignored and arbitration is pure round-robin.

## Test plan
- Reset, then A loads R2 = 0x1234 -> RegE = 0100 for one cycle with RegFunSel = 10 and RegI = 0x1234. RspValid comes 3 cycles after accept, with RspData = 0x1234 and RspOwner = 0.
- R1 = 0x0000, B decrements R1, then increments it twice -> responses 0xFFFF, 0x0000, 0x0001.
- A and B both valid continuously -> grants alternate A, B, A, B. A waiting requester's fields stay latched only upon its own Ready.
- RspReady held low for 5 cycles -> RspValid, RspData and RspOwner stay stable, both Ready outputs stay 0, and no RegE pulse occurs.
- Reset pulsed low during ISSUE -> all outputs return to reset values asynchronously. After release, the first tie is granted to A.
- With REG_BANK_ARB_LOCK_EN, A issues Lock = 1 while both requesters are valid -> A wins twice in a row before B. Without the macro, the order is A, B.
